// File: rtl/lattice_pkg.sv
// Shared constants, slot-state encoding and row-enable helper for the lattice panel scanner.
package lattice_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int HSTEPS = 16;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Active-low one-hot row enable for a row index.
    function automatic logic [ROWS-1:0] row_onehot_n(input logic [2:0] idx);
        logic [ROWS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/lattice_tick_div.sv
// Modulo-N counter with synchronous clear; publishes its next count and a wrap pulse.
module lattice_tick_div #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt_next,
    output logic         o_wrap
);

    localparam logic [W-1:0] LP_LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    // The wrap pulse is raw; callers gate it against their own clear condition.
    always_comb begin
        o_wrap = i_en && (r_cnt == LP_LAST);
        if (i_clr || o_wrap) begin
            o_cnt_next = '0;
        end else if (i_en) begin
            o_cnt_next = r_cnt + 1'b1;
        end else begin
            o_cnt_next = r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_next;
        end
    end

endmodule

// File: rtl/lattice_scan.sv
// Row-scan / scroll timing master for the 8x8 bicolour panel.
// Optional macro LATTICE_DIM_EN adds a dim input that halves the lit part of each row slot.
module lattice_scan
    import lattice_pkg::*;
#(
    parameter int ROW_DIV    = 1000,
    parameter int BLANK_CYC  = 8,
    parameter int SCROLL_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       onride,
    input  logic [7:0] lat_led,
`ifdef LATTICE_DIM_EN
    input  logic       dim,
`endif
    output logic [2:0] lat_Vcnt,
    output logic [3:0] lat_Hcnt,
    output logic [7:0] row_sel_n,
    output logic [7:0] col_R,
    output logic [7:0] col_G,
    output logic       frame_tick
);

    localparam int SW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SW-1:0] LP_BLANK = SW'(BLANK_CYC);
`ifdef LATTICE_DIM_EN
    localparam logic [SW-1:0] LP_HALF = SW'(ROW_DIV / 2);
`endif

    logic [2:0]    r_lat_vcnt;
    logic [3:0]    r_lat_hcnt;
    logic [7:0]    r_row_sel_n;
    logic [7:0]    r_col_r;
    logic [7:0]    r_col_g;
    logic          r_frame_tick;
    logic          r_onride_q;

    logic          w_resync;
    logic [SW-1:0] w_slot_next;
    logic          w_slot_wrap;
    logic          w_frame_end;
    logic [FW-1:0] w_frame_cnt_unused;
    logic          w_frame_wrap;
    logic [1:0]    w_state_next;

    assign w_resync    = (onride != r_onride_q);
    assign w_frame_end = w_slot_wrap && (r_lat_vcnt == 3'(ROWS - 1)) && !w_resync;

    lattice_tick_div #(.N(ROW_DIV), .W(SW)) u_slot_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_resync),
        .i_en       (1'b1),
        .o_cnt_next (w_slot_next),
        .o_wrap     (w_slot_wrap)
    );

    lattice_tick_div #(.N(SCROLL_DIV), .W(FW)) u_frame_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_resync),
        .i_en       (w_frame_end),
        .o_cnt_next (w_frame_cnt_unused),
        .o_wrap     (w_frame_wrap)
    );

    // Decode from the upcoming slot count so registered outputs line up with slot_cnt.
    always_comb begin
        w_state_next = ST_SHOW;
        if (w_slot_next < LP_BLANK) begin
            w_state_next = ST_BLANK;
        end else if (w_slot_next == LP_BLANK) begin
            w_state_next = ST_LOAD;
        end
`ifdef LATTICE_DIM_EN
        else if (dim && (w_slot_next >= LP_HALF)) begin
            w_state_next = ST_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lat_vcnt   <= '0;
            r_lat_hcnt   <= '0;
            r_row_sel_n  <= 8'hFF;
            r_col_r      <= '0;
            r_col_g      <= '0;
            r_frame_tick <= 1'b0;
            r_onride_q   <= onride;
        end else begin
            r_onride_q   <= onride;
            r_frame_tick <= 1'b0;
            if (w_resync) begin
                r_lat_vcnt  <= '0;
                r_lat_hcnt  <= '0;
                r_row_sel_n <= 8'hFF;
                r_col_r     <= '0;
                r_col_g     <= '0;
            end else begin
                if (w_slot_wrap) begin
                    r_lat_vcnt <= r_lat_vcnt + 3'd1;
                end
                if (w_frame_end) begin
                    r_frame_tick <= 1'b1;
                end
                if (w_frame_wrap) begin
                    r_lat_hcnt <= r_lat_hcnt + 4'd1;
                end
                case (w_state_next)
                    ST_LOAD: begin
                        r_row_sel_n <= 8'hFF;
                        r_col_r     <= onride ? 8'h00 : lat_led;
                        r_col_g     <= onride ? lat_led : 8'h00;
                    end
                    ST_SHOW: r_row_sel_n <= row_onehot_n(r_lat_vcnt);
                    default: r_row_sel_n <= 8'hFF;
                endcase
            end
        end
    end

    assign lat_Vcnt   = r_lat_vcnt;
    assign lat_Hcnt   = r_lat_hcnt;
    assign row_sel_n  = r_row_sel_n;
    assign col_R      = r_col_r;
    assign col_G      = r_col_g;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_lattice_scan.sv
// Directed bench for lattice_scan with ROW_DIV=10, BLANK_CYC=2, SCROLL_DIV=2.
module tb_lattice_scan;

    localparam int ROW_DIV    = 10;
    localparam int BLANK_CYC  = 2;
    localparam int SCROLL_DIV = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       onride  = 1'b0;
    logic [7:0] lat_led = 8'h00;
`ifdef LATTICE_DIM_EN
    logic       dim     = 1'b0;
`endif
    logic [2:0] lat_Vcnt;
    logic [3:0] lat_Hcnt;
    logic [7:0] row_sel_n;
    logic [7:0] col_R;
    logic [7:0] col_G;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;
    logic [7:0] exp_q[$];

    lattice_scan #(
        .ROW_DIV    (ROW_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .onride     (onride),
        .lat_led    (lat_led),
`ifdef LATTICE_DIM_EN
        .dim        (dim),
`endif
        .lat_Vcnt   (lat_Vcnt),
        .lat_Hcnt   (lat_Hcnt),
        .row_sel_n  (row_sel_n),
        .col_R      (col_R),
        .col_G      (col_G),
        .frame_tick (frame_tick)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench in cycle 0 (slot_cnt 0) with reset released.
    task automatic do_reset(input logic ride, input logic [7:0] led);
        rst_n   = 1'b0;
        onride  = ride;
        lat_led = led;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // reset state
        do_reset(1'b0, 8'hA5);
        check_eq("rst_vcnt", 32'(lat_Vcnt), 32'(0));
        check_eq("rst_hcnt", 32'(lat_Hcnt), 32'(0));
        check_eq("rst_row", 32'(row_sel_n), 32'(8'hFF));
        check_eq("rst_col_r", 32'(col_R), 32'(0));
        check_eq("rst_col_g", 32'(col_G), 32'(0));
        check_eq("rst_tick", 32'(frame_tick), 32'(0));

        // row timing through the first slot
        for (int k = 0; k <= 10; k++) exp_q.push_back((k >= 3 && k <= 9) ? 8'hFE : 8'hFF);
        for (int k = 0; k <= 10; k++) begin
            check_eq("row_timing", 32'(row_sel_n), 32'(exp_q.pop_front()));
            if (k < 2) check_eq("col_r_pre_load", 32'(col_R), 32'(0));
            if (k == 2) begin
                check_eq("col_r_load", 32'(col_R), 32'(8'hA5));
                check_eq("col_g_load", 32'(col_G), 32'(0));
            end
            if (k < 10) step();
        end
        check_eq("vcnt_row1", 32'(lat_Vcnt), 32'(1));
        lat_led = 8'h5A;
        step();
        check_eq("col_r_hold", 32'(col_R), 32'(8'hA5));
        step();
        check_eq("col_r_load2", 32'(col_R), 32'(8'h5A));
        step();
        check_eq("row1_on", 32'(row_sel_n), 32'(8'hFD));

        // free-run over 32 frames: tick every 80, scroll step every 160
        while (cyc < 2561) begin
            step();
            check_eq("frame_tick", 32'(frame_tick), 32'(cyc % 80 == 0));
            check_eq("hcnt", 32'(lat_Hcnt), 32'((cyc / 160) % 16));
            check_eq("vcnt", 32'(lat_Vcnt), 32'((cyc / 10) % 8));
        end
        check_eq("hcnt_wrap", 32'(lat_Hcnt), 32'(0));

        // colour select while carrying a passenger
        do_reset(1'b1, 8'h3C);
        step();
        check_eq("g_pre_load", 32'(col_G), 32'(0));
        step();
        check_eq("g_load0", 32'(col_G), 32'(8'h3C));
        check_eq("r_load0", 32'(col_R), 32'(0));
        step();
        check_eq("g_row0_on", 32'(row_sel_n), 32'(8'hFE));
        run_until(12);
        check_eq("g_load1", 32'(col_G), 32'(8'h3C));
        check_eq("r_load1", 32'(col_R), 32'(0));
        step();
        check_eq("g_row1_on", 32'(row_sel_n), 32'(8'hFD));

        // resync mid-frame with lat_Hcnt=3
        do_reset(1'b0, 8'h81);
        run_until(525);
        check_eq("pre_rs_hcnt", 32'(lat_Hcnt), 32'(3));
        check_eq("pre_rs_vcnt", 32'(lat_Vcnt), 32'(4));
        check_eq("pre_rs_row", 32'(row_sel_n), 32'(8'hEF));
        check_eq("pre_rs_col_r", 32'(col_R), 32'(8'h81));
        onride = 1'b1;
        step();
        check_eq("rs_vcnt", 32'(lat_Vcnt), 32'(0));
        check_eq("rs_hcnt", 32'(lat_Hcnt), 32'(0));
        check_eq("rs_row", 32'(row_sel_n), 32'(8'hFF));
        check_eq("rs_col_r", 32'(col_R), 32'(0));
        check_eq("rs_col_g", 32'(col_G), 32'(0));
        check_eq("rs_tick", 32'(frame_tick), 32'(0));
        base = cyc;
        run_until(base + 2);
        check_eq("rs_load_g", 32'(col_G), 32'(8'h81));
        check_eq("rs_load_r", 32'(col_R), 32'(0));
        run_until(base + 79);
        check_eq("rs_tick_early", 32'(frame_tick), 32'(0));
        step();
        check_eq("rs_tick_new", 32'(frame_tick), 32'(1));

        // resync landing on the frame-end edge that would also step lat_Hcnt
        run_until(base + 159);
        check_eq("fe_pre_vcnt", 32'(lat_Vcnt), 32'(7));
        check_eq("fe_pre_hcnt", 32'(lat_Hcnt), 32'(0));
        onride = 1'b0;
        step();
        check_eq("fe_rs_tick", 32'(frame_tick), 32'(0));
        check_eq("fe_rs_hcnt", 32'(lat_Hcnt), 32'(0));
        check_eq("fe_rs_vcnt", 32'(lat_Vcnt), 32'(0));
        check_eq("fe_rs_row", 32'(row_sel_n), 32'(8'hFF));
        check_eq("fe_rs_col_g", 32'(col_G), 32'(0));
        base = cyc;
        run_until(base + 80);
        check_eq("fe_tick_new", 32'(frame_tick), 32'(1));
        check_eq("fe_vcnt_new", 32'(lat_Vcnt), 32'(0));

        // reset asserted while a row is lit
        run_until(base + 85);
        check_eq("mid_row_on", 32'(row_sel_n), 32'(8'hFE));
        check_eq("mid_col_r", 32'(col_R), 32'(8'h81));
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_row", 32'(row_sel_n), 32'(8'hFF));
        check_eq("mid_rst_col_r", 32'(col_R), 32'(0));
        check_eq("mid_rst_tick", 32'(frame_tick), 32'(0));
        rst_n = 1'b1;

`ifdef LATTICE_DIM_EN
        // dimmed slot: lit only for slot_cnt 3..4
        dim = 1'b1;
        do_reset(1'b0, 8'h11);
        for (int k = 0; k < 10; k++) begin
            check_eq("dim_row", 32'(row_sel_n), 32'((k == 3 || k == 4) ? 8'hFE : 8'hFF));
            step();
        end
        check_eq("dim_vcnt", 32'(lat_Vcnt), 32'(1));
        dim = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
